mv_host_sequencer: RTL
======================

Name: mv_host_sequencer

Overview:
Host-side initiator for the P=2 matrix-vector accelerator: the other end of its ps_control/pl_status handshake and its BRAM ports.
- Accepts W (row-major) and x as a 32-bit valid/ready input stream and writes them into the W1/W2/x BRAMs.
- Zeroes y1/y2, which the accelerator accumulates into, then raises start and waits for done.
- Acknowledges done, then reads y1 followed by y2 and sends them out as a valid/ready output stream.

Parameters:
- addr_W_size, 16, W BRAM byte-address width.
- addr_x_size, 12, x BRAM byte-address width.
- addr_y_size, 12, y BRAM byte-address width.
- length_M, 128, rows of W and length of y; must be even.
- length_N, 128, columns of W and length of x.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- go  in  1  one-cycle pulse; starts a job, honoured only in IDLE
- busy  out  1  high in every state except IDLE
- s_valid / s_ready / s_data  in / out / in  1 / 1 / 32  load stream: W words first, then x
- m_valid / m_ready / m_data  out / in / out  1 / 1 / 32  result stream: y[0..M-1]
- ps_control  out  32  bit0 = start; bits 31:1 = 0
- pl_status  in  32  bit0 = accelerator done
- bram_addr_W1, bram_addr_W2  out  addr_W_size  W BRAM byte addresses
- bram_wrdata_W1, bram_wrdata_W2  out  32  W BRAM write data
- bram_we_W1, bram_we_W2  out  4  W BRAM byte write enables
- bram_addr_x, bram_wrdata_x, bram_we_x  out  addr_x_size, 32, 4  x BRAM port
- bram_addr_y1, bram_addr_y2  out  addr_y_size  y BRAM byte addresses
- bram_wrdata_y1, bram_wrdata_y2  out  32  y BRAM write data
- bram_we_y1, bram_we_y2  out  4  y BRAM byte write enables
- bram_rddata_y1, bram_rddata_y2  in  32  y BRAM read data, 1-cycle latency

Behaviour:
Reset:
- All we = 0, all addresses = 0, ps_control = 0.
- s_ready = 0, m_valid = 0, m_data = 0, busy = 0, state = IDLE.
- Reset in any state aborts the job immediately; no further BRAM writes occur.

IDLE:
- go=1 -> LOAD_W; word counter k = 0.

LOAD_W:
- s_ready = 1.
- Each handshake writes word k, with H = M/2 and r = k/N, c = k mod N:
  - k < H*N: write W1 at byte address 4*(r*N + c).
  - otherwise: write W2 at byte address 4*((r-H)*N + c).
- Only the selected bank gets we = 4'hf, in the handshake cycle only; the other bank's we = 0.
- After M*N words -> LOAD_X.

LOAD_X:
- s_ready = 1.
- Word j is written to x at address 4*j.
- After N words -> CLR_Y; s_ready drops in the same cycle the last word is accepted.

CLR_Y:
- Writes 0 to y1 and y2 at address 4*i in parallel for i = 0..H-1, one word per cycle, we = 4'hf.
- Then -> START.

START:
- ps_control[0] = 1; all BRAM we = 0; BRAM addresses held at 0.
- Waits for pl_status[0] = 1 -> ACK.

ACK:
- ps_control[0] = 0.
- Waits for pl_status[0] = 0 -> DRAIN.

DRAIN:
- Reads y1[0..H-1], then y2[0..H-1].
- Per word:
  - Drive the address (cycle 0).
  - Capture rddata into m_data with m_valid = 1 (cycle 1).
  - Hold m_data/m_valid until m_ready = 1.
  - The cycle after the handshake, drive the next address.
- Throughput is at most 1 word per 2 cycles.
- After the M-th handshake -> IDLE; m_valid drops the next cycle.

Other rules:
- go outside IDLE is ignored.
- s_valid while s_ready = 0 is ignored (no write, no count).
- Stream words have no side-band framing; the counters alone define boundaries.
- All counters are M*N-sized, with no wrap-around within a job.
- Unused wrdata outputs are 0.
- The y BRAMs use their wrdata ports only in CLR_Y (zeros).
- busy falls in the same cycle state returns to IDLE.

Test Plan:
1. M=4, N=4, go, 16 W words 1..16, then x 17..20, s_valid held high:
   - W1 addr 0,4,..,28 gets 1..8; W2 addr 0..28 gets 9..16; x addr 0..12 gets 17..20.
   - Exactly 20 we pulses, zero stall cycles.
2. Load complete:
   - y1/y2 addr 0,4 written with 0 over 2 cycles.
   - ps_control becomes 1 and stays 1 with pl_status=0 for 50 cycles.
   - pl_status=1 -> ps_control=0 next cycle.
   - pl_status held 1 for 5 more cycles -> still ACK, no reads issued.
3. Drain with bram_rddata_y1 = {A,B} and y2 = {C,D}, m_ready always 1:
   - m_data sequence A,B,C,D, with m_valid high every other cycle.
   - Returns to IDLE with busy=0.
4. Drain with m_ready low for 7 cycles on word B:
   - m_data stays B and m_valid stays 1 throughout.
   - No address advance; C follows 2 cycles after the handshake.
5. s_valid toggling 1,0,1,0 in LOAD_W, and go pulsed mid-load:
   - Only the valid cycles write; addresses stay contiguous; go has no effect.
6. reset asserted in LOAD_X after 2 x words, then released:
   - All we=0 next cycle, ps_control=0, IDLE.
   - A fresh go reloads from W1 addr 0.

Source files
------------

// File: rtl/mv_host_sequencer_if.sv
// 32-bit valid/ready stream bundle, used for both the load stream and the result stream.
interface mv_host_sequencer_if;
  logic        valid;
  logic        ready;
  logic [31:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/mv_host_sequencer.sv
// Host-side sequencer for the P=2 matrix-vector accelerator: loads W/x from a stream,
// clears y, starts the accelerator, waits for done, then streams y1 followed by y2 out.
module mv_host_sequencer #(
  parameter int addr_W_size = 16,
  parameter int addr_x_size = 12,
  parameter int addr_y_size = 12,
  parameter int length_M    = 128,
  parameter int length_N    = 128
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   go,
  output logic                   busy,
  mv_host_sequencer_if.slave     s_if,
  mv_host_sequencer_if.master    m_if,
  output logic [31:0]            ps_control,
  input  logic [31:0]            pl_status,
  output logic [addr_W_size-1:0] bram_addr_W1,
  output logic [addr_W_size-1:0] bram_addr_W2,
  output logic [31:0]            bram_wrdata_W1,
  output logic [31:0]            bram_wrdata_W2,
  output logic [3:0]             bram_we_W1,
  output logic [3:0]             bram_we_W2,
  output logic [addr_x_size-1:0] bram_addr_x,
  output logic [31:0]            bram_wrdata_x,
  output logic [3:0]             bram_we_x,
  output logic [addr_y_size-1:0] bram_addr_y1,
  output logic [addr_y_size-1:0] bram_addr_y2,
  output logic [31:0]            bram_wrdata_y1,
  output logic [31:0]            bram_wrdata_y2,
  output logic [3:0]             bram_we_y1,
  output logic [3:0]             bram_we_y2,
  input  logic [31:0]            bram_rddata_y1,
  input  logic [31:0]            bram_rddata_y2
);
  localparam int H  = length_M / 2;
  localparam int HN = H * length_N;
  localparam int MN = length_M * length_N;
  localparam int CW = $clog2(MN + 1);

  typedef enum logic [2:0] {
    IDLE, LOAD_W, LOAD_X, CLR_Y, START, ACK, DRAIN_ADDR, DRAIN_DATA
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic          held_q, held_d;
  logic [31:0]   m_data_q, m_data_d;
  logic          s_hs, m_hs, w1_sel, y1_sel;
  logic [31:0]   rd_sel, m_word;
  logic          unused_status;

  assign unused_status = ^pl_status[31:1];
  assign cnt_inc       = cnt_q + CW'(1);
  assign w1_sel        = cnt_q < CW'(HN);
  assign y1_sel        = cnt_q < CW'(H);
  assign busy          = state_q != IDLE;
  // reset also blocks the handshake so nothing is written on the abort cycle
  assign s_if.ready    = ~reset && (state_q == LOAD_W || state_q == LOAD_X);
  assign s_hs          = s_if.valid && s_if.ready;
  assign m_hs          = m_if.valid && m_if.ready;
  assign rd_sel        = y1_sel ? bram_rddata_y1 : bram_rddata_y2;
  // first data cycle passes the BRAM word through; later stall cycles replay the capture
  assign m_word        = held_q ? m_data_q : rd_sel;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      held_q   <= 1'b0;
      m_data_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      held_q   <= held_d;
      m_data_q <= m_data_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    held_d   = 1'b0;
    m_data_d = '0;
    unique case (state_q)
      IDLE: if (go) begin
        state_d = LOAD_W;
        cnt_d   = '0;
      end
      LOAD_W: if (s_hs) begin
        if (cnt_q == CW'(MN - 1)) begin
          state_d = LOAD_X;
          cnt_d   = '0;
        end else cnt_d = cnt_inc;
      end
      LOAD_X: if (s_hs) begin
        if (cnt_q == CW'(length_N - 1)) begin
          state_d = CLR_Y;
          cnt_d   = '0;
        end else cnt_d = cnt_inc;
      end
      CLR_Y: begin
        if (cnt_q == CW'(H - 1)) begin
          state_d = START;
          cnt_d   = '0;
        end else cnt_d = cnt_inc;
      end
      START: if (pl_status[0]) state_d = ACK;
      ACK: if (!pl_status[0]) begin
        state_d = DRAIN_ADDR;
        cnt_d   = '0;
      end
      DRAIN_ADDR: state_d = DRAIN_DATA;
      DRAIN_DATA: begin
        held_d   = 1'b1;
        m_data_d = m_word;
        if (m_hs) begin
          if (cnt_q == CW'(length_M - 1)) state_d = IDLE;
          else begin
            state_d = DRAIN_ADDR;
            cnt_d   = cnt_inc;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bram_addr_W1   = '0;
    bram_addr_W2   = '0;
    bram_wrdata_W1 = '0;
    bram_wrdata_W2 = '0;
    bram_we_W1     = '0;
    bram_we_W2     = '0;
    bram_addr_x    = '0;
    bram_wrdata_x  = '0;
    bram_we_x      = '0;
    bram_addr_y1   = '0;
    bram_addr_y2   = '0;
    bram_wrdata_y1 = '0;
    bram_wrdata_y2 = '0;
    bram_we_y1     = '0;
    bram_we_y2     = '0;
    ps_control     = '0;
    m_if.valid     = 1'b0;
    m_if.data      = '0;
    unique case (state_q)
      LOAD_W: begin
        if (w1_sel) begin
          bram_addr_W1   = addr_W_size'({cnt_q, 2'b00});
          bram_wrdata_W1 = s_if.data;
          bram_we_W1     = {4{s_hs}};
        end else begin
          bram_addr_W2   = addr_W_size'({cnt_q - CW'(HN), 2'b00});
          bram_wrdata_W2 = s_if.data;
          bram_we_W2     = {4{s_hs}};
        end
      end
      LOAD_X: begin
        bram_addr_x   = addr_x_size'({cnt_q, 2'b00});
        bram_wrdata_x = s_if.data;
        bram_we_x     = {4{s_hs}};
      end
      CLR_Y: begin
        bram_addr_y1 = addr_y_size'({cnt_q, 2'b00});
        bram_addr_y2 = addr_y_size'({cnt_q, 2'b00});
        bram_we_y1   = {4{~reset}};
        bram_we_y2   = {4{~reset}};
      end
      START: ps_control = 32'd1;
      DRAIN_ADDR, DRAIN_DATA: begin
        if (y1_sel) bram_addr_y1 = addr_y_size'({cnt_q, 2'b00});
        else        bram_addr_y2 = addr_y_size'({cnt_q - CW'(H), 2'b00});
        if (state_q == DRAIN_DATA) begin
          m_if.valid = 1'b1;
          m_if.data  = m_word;
        end
      end
      default: ;
    endcase
  end
endmodule
